mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single 512x32 remote memory port of the design wrapper (mem_addr / mem_wr_data / mem_rd_data / mem_wr). It sits between the host command path (requester 0, driven from the UART interface registers) and an on-chip engine (requester 1). It runs one access per cycle with round-robin fairness and optional bounded burst locking. Addresses, write data and write strobe are registered; read data returns with a fixed latency.

## Interface
- ADDR_W, 9, memory word-address width
- DATA_W, 32, memory data width
- MAX_BURST, 4, maximum consecutive grants to a locking owner while the other side waits (>=1)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  2  per-requester access request; hold with cmd fields stable until gnt
- lock  in  2  per-requester burst hint; sampled with req
- wr  in  2  per-requester command type: 1 write, 0 read
- addr0, addr1  in  ADDR_W each  per-requester word address
- wdata0, wdata1  in  DATA_W each  per-requester write data
- gnt  out  2  combinational, one-hot or zero; request accepted this cycle
- rvalid  out  2  registered; read data valid for the indicated requester
- rdata  out  DATA_W  shared read data; equals mem_rd_data when |rvalid, else 0
- owner  out  1  registered; last granted requester
- mem_addr  out  ADDR_W  registered memory address
- mem_wr_data  out  DATA_W  registered memory write data
- mem_wr  out  1  registered write strobe, one cycle per write
- mem_rd_data  in  DATA_W  synchronous-RAM read data, valid one cycle after mem_addr

## Operation
- FSM states: IDLE (no grant last cycle), OWN0, OWN1. The state is the owner of the previous cycle's grant. burst_cnt (width clog2(MAX_BURST+1)) counts consecutive grants to the current owner and saturates at MAX_BURST.
- Arbitration, evaluated combinationally each cycle:
  - Only one side requests: that side is granted.
  - Both request, current owner X has req[X]&lock[X] and burst_cnt<MAX_BURST: X is granted.
  - Both request otherwise: the side that is not `owner` is granted (round-robin).
  - Neither requests: gnt=0, next state IDLE, burst_cnt=0.
- On a grant to i: next state OWNi. burst_cnt becomes burst_cnt+1 if i equals the previous owner and the state was not IDLE; otherwise 1. owner<=i.
- A grant with lock deasserted still counts toward burst_cnt. Lock only extends ownership against a competing request.
- A solitary locking requester keeps being granted past MAX_BURST. burst_cnt saturates. When the other side asserts req, ownership switches on that cycle.
- Pipeline stage 1 (cycle after grant): mem_addr, mem_wr_data = selected fields; mem_wr = wr of the granted requester; rd_pend = ~wr; rd_id = i.
- Stage 2: rvalid[rd_id] <= rd_pend. All other rvalid bits are 0.
- Memory order equals grant order. A read granted after a write to the same address returns the new data.
- Idle cycles: mem_wr=0. mem_addr and mem_wr_data hold their last values.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, owner=1 (so requester 0 wins the first tie), state IDLE, burst_cnt=0, mem_addr=0, mem_wr_data=0, mem_wr=0.
- Grant in cycle T → mem_addr/mem_wr in T+1 → for a read, rvalid and rdata in T+2. Read latency is 2 cycles after gnt.
- Throughput: one access per cycle. Back-to-back grants produce back-to-back rvalid pulses with no bubbles.
- Requester rule: req/wr/addr/wdata must not change while req=1 and gnt=0. The cycle after gnt, the requester may present a new command.
- Reset mid-operation: all in-flight reads are dropped. No rvalid is issued after rst deasserts for a command granted before reset.
- Simultaneous rvalid and a new gnt to the same requester in one cycle are legal and independent.

## Test plan
- Reset, then req=2'b11, no lock → gnt alternates 01,10,01,10. owner starts at 0.
- req0 writes 0x1FF←0xDEADBEEF; next cycle req0 reads 0x1FF → mem_wr=1 with mem_addr=0x1FF in T+1. rvalid=01 and rdata=0xDEADBEEF two cycles after the read gnt.
- MAX_BURST=4, lock0=1, req=11 continuous → exactly 4 consecutive gnt0, then 1 gnt1, then 4 gnt0 again.
- lock1=1 with only req1 for 10 cycles → 10 consecutive gnt1. Then req0 rises → gnt0 in that same cycle.
- Interleaved reads from both sides to addresses 0x000/0x001 → rvalid bits follow grant order exactly, 2 cycles delayed, with correct per-address data.
- Read granted, rst pulsed in the next cycle → rvalid stays 0 and all outputs take their reset values asynchronously.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded burst locking in front of a single
// synchronous-RAM port; registered command stage, read data after two cycles.
//
// state | meaning
// IDLE  | no grant in the previous cycle
// OWN0  | requester 0 was granted in the previous cycle
// OWN1  | requester 1 was granted in the previous cycle
module mem_port_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  logic [1:0]        wr,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              owner,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic [CW-1:0] burst_cnt;
  logic          rd_pend;
  logic          rd_id;
  logic          gnt_any;
  logic          gnt_id;

  always_comb begin
    gnt_any = |req;
    gnt_id  = 1'b0;
    if (req == 2'b10) begin
      gnt_id = 1'b1;
    end else if (req == 2'b11) begin
      // A locking owner keeps the port against a competitor until its burst is used up.
      if (lock[owner] && (burst_cnt < MAX_CNT)) gnt_id = owner;
      else                                      gnt_id = ~owner;
    end
    gnt = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      owner       <= 1'b1;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wr      <= 1'b0;
      rd_pend     <= 1'b0;
      rd_id       <= 1'b0;
      rvalid      <= 2'b00;
    end else begin
      if (gnt_any) begin
        state <= gnt_id ? OWN1 : OWN0;
        owner <= gnt_id;
        if ((state != IDLE) && (gnt_id == owner))
          burst_cnt <= (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + CW'(1);
        else
          burst_cnt <= CW'(1);
        mem_addr    <= gnt_id ? addr1 : addr0;
        mem_wr_data <= gnt_id ? wdata1 : wdata0;
        mem_wr      <= wr[gnt_id];
        rd_pend     <= ~wr[gnt_id];
        rd_id       <= gnt_id;
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
        mem_wr    <= 1'b0;
        rd_pend   <= 1'b0;
      end
      rvalid <= rd_pend ? (rd_id ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign rdata = (|rvalid) ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 512x32 synchronous RAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, lock, wr;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        owner;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr;
  logic [31:0] mem_rd_data;

  logic [31:0] ram [512];

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wr(wr),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .owner(owner),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's command just after the falling edge; checks follow at +1.
  task automatic step(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                      input logic [8:0] a0, input logic [8:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    req = r; lock = l; wr = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    #1;
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);
  endtask

  logic [1:0]  exp_g   [10];
  logic [1:0]  exp_rv  [6];
  logic [31:0] exp_rd  [6];

  initial begin
    rst = 1'b1; req = 0; lock = 0; wr = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    #12;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_owner", 32'(owner), 32'h1);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wr_data", mem_wr_data, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    @(negedge clk); rst = 1'b0;

    // plain round robin
    step(2'b11, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0); chk("rr_g0", 32'(gnt), 32'h1);
    step(2'b11, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0); chk("rr_g1", 32'(gnt), 32'h2);
    chk("rr_owner0", 32'(owner), 32'h0);
    step(2'b11, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0); chk("rr_g2", 32'(gnt), 32'h1);
    chk("rr_owner1", 32'(owner), 32'h1);
    step(2'b11, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0); chk("rr_g3", 32'(gnt), 32'h2);
    idle(); idle(); idle();

    // write then read of the top address
    step(2'b01, 2'b00, 2'b01, 9'h1FF, 9'h0, 32'hDEADBEEF, 32'h0); chk("wr_gnt", 32'(gnt), 32'h1);
    step(2'b01, 2'b00, 2'b00, 9'h1FF, 9'h0, 32'h0, 32'h0);        chk("rd_gnt", 32'(gnt), 32'h1);
    chk("wr_mem_wr", 32'(mem_wr), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h1FF);
    chk("wr_mem_data", mem_wr_data, 32'hDEADBEEF);
    idle();
    chk("rd_s1_mem_wr", 32'(mem_wr), 32'h0);
    chk("rd_s1_rvalid", 32'(rvalid), 32'h0);
    idle();
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    idle();
    chk("rd_rvalid_done", 32'(rvalid), 32'h0);
    chk("idle_mem_addr_hold", 32'(mem_addr), 32'h1FF);

    // bounded burst for a locking requester 0
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int k = 0; k < 10; k++) begin
      step(2'b11, 2'b01, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);
      chk($sformatf("burst_g%0d", k), 32'(gnt), 32'(exp_g[k]));
    end
    idle(); idle();

    // solitary locking requester 1 runs past the burst limit
    for (int k = 0; k < 10; k++) begin
      step(2'b10, 2'b10, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);
      chk($sformatf("solo_g%0d", k), 32'(gnt), 32'h2);
    end
    step(2'b11, 2'b10, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0);
    chk("solo_switch", 32'(gnt), 32'h1);
    idle(); idle();

    // interleaved reads from both sides
    step(2'b01, 2'b00, 2'b01, 9'h000, 9'h0, 32'h11111111, 32'h0); chk("il_w0", 32'(gnt), 32'h1);
    step(2'b10, 2'b00, 2'b10, 9'h0, 9'h001, 32'h0, 32'h22222222); chk("il_w1", 32'(gnt), 32'h2);
    idle(); idle();
    exp_g[0:3] = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rv = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd = '{32'h0, 32'h0, 32'h22222222, 32'h11111111, 32'h22222222, 32'h11111111};
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        step(2'b11, 2'b00, 2'b00, 9'h001, 9'h000, 32'h0, 32'h0);
        chk($sformatf("il_g%0d", k), 32'(gnt), 32'(exp_g[k]));
      end else begin
        idle();
      end
      chk($sformatf("il_rv%0d", k), 32'(rvalid), 32'(exp_rv[k]));
      chk($sformatf("il_rd%0d", k), rdata, exp_rd[k]);
    end

    // reset while a read is in flight
    step(2'b01, 2'b00, 2'b00, 9'h1FF, 9'h0, 32'h5A5A5A5A, 32'h0); chk("rr_rd_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 2'b00;
    rst = 1'b1;
    #1;
    chk("mrst_mem_addr", 32'(mem_addr), 32'h0);
    chk("mrst_mem_wr_data", mem_wr_data, 32'h0);
    chk("mrst_owner", 32'(owner), 32'h1);
    chk("mrst_rvalid", 32'(rvalid), 32'h0);
    chk("mrst_gnt", 32'(gnt), 32'h0);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk($sformatf("mrst_drop%0d", k), 32'(rvalid), 32'h0);
    end
    chk("mrst_rdata", rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
